// File: rtl/measurement_readout_pkg.sv
// Shared definitions for the measurement readout path: sync byte, sequence width,
// FSM state encoding and the frame-length helper.
package measurement_readout_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam int         SEQ_BITS  = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_GAP
  } readout_state_e;

  // A frame is the sync byte, the sequence number and two saturated time fields.
  function automatic int frame_len(input int out_bits);
    return 8 + SEQ_BITS + 2 * out_bits;
  endfunction

endpackage

// File: rtl/measurement_readout_if.sv
// Measurement-in / serial-out signal bundle of the readout block.
interface measurement_readout_if #(
  parameter int DATA_BITS  = 32,
  parameter int FIFO_DEPTH = 4
);
  localparam int LEVEL_BITS = $clog2(FIFO_DEPTH) + 1;

  logic                  pulse;
  logic [DATA_BITS-1:0]  time_high;
  logic [DATA_BITS-1:0]  time_low;
  logic                  clr_ovf;
  logic                  sck;
  logic                  sdo;
  logic                  sframe;
  logic                  overflow;
  logic [LEVEL_BITS-1:0] fifo_level;

  modport master (
    output pulse, time_high, time_low, clr_ovf,
    input  sck, sdo, sframe, overflow, fifo_level
  );

  modport slave (
    input  pulse, time_high, time_low, clr_ovf,
    output sck, sdo, sframe, overflow, fifo_level
  );

endinterface

// File: rtl/measurement_readout_fifo.sv
// Small synchronous FIFO for captured measurements; a pop frees room for a push
// arriving in the same cycle, even when full.
module measurement_readout_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (do_push && !do_pop) begin
        level <= level + 1'b1;
      end else if (do_pop && !do_push) begin
        level <= level - 1'b1;
      end
    end
  end

endmodule

// File: rtl/measurement_readout.sv
// Captures frequency-counter results on PULSE into a FIFO and ships each entry
// as a fixed-length frame over an SCK/SDO/SFRAME serial link.
module measurement_readout
  import measurement_readout_pkg::*;
#(
  parameter int DATA_BITS  = 32,
  parameter int OUT_BITS   = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int CLK_DIV    = 4,
  parameter int GAP_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  measurement_readout_if.slave  bus
);

  localparam int FL         = frame_len(OUT_BITS);
  localparam int ENTRY_BITS = SEQ_BITS + 2 * OUT_BITS;
  localparam int LEVEL_BITS = $clog2(FIFO_DEPTH) + 1;
  localparam int BIT_BITS   = $clog2(FL);
  localparam int DIV_BITS   = $clog2(CLK_DIV);
  localparam int GAP_BITS   = $clog2(GAP_CYCLES + 1);

  function automatic logic [OUT_BITS-1:0] sat(input logic [DATA_BITS-1:0] x);
    return ((x >> OUT_BITS) != '0) ? '1 : x[OUT_BITS-1:0];
  endfunction

  readout_state_e        state;
  logic [SEQ_BITS-1:0]   seq;
  logic                  overflow;
  logic                  pop;
  logic                  drop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [ENTRY_BITS-1:0] fifo_din;
  logic [ENTRY_BITS-1:0] fifo_dout;
  logic [LEVEL_BITS-1:0] level;
  logic [FL-1:0]         frame_word;
  logic [FL-1:0]         shift_reg;
  logic [BIT_BITS-1:0]   bit_cnt;
  logic [DIV_BITS-1:0]   div_cnt;
  logic [GAP_BITS-1:0]   gap_cnt;
  logic                  sck;
  logic                  sdo;
  logic                  sframe;

  assign pop        = (state == ST_LOAD);
  assign drop       = bus.pulse && fifo_full && !pop;
  assign fifo_din   = {seq, sat(bus.time_high), sat(bus.time_low)};
  assign frame_word = {SYNC_BYTE, fifo_dout};

  assign bus.sck        = sck;
  assign bus.sdo        = sdo;
  assign bus.sframe     = sframe;
  assign bus.overflow   = overflow;
  assign bus.fifo_level = level;

  measurement_readout_fifo #(
    .WIDTH (ENTRY_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (bus.pulse),
    .pop   (pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );

  // Sequence advances on every strobe, dropped or not, so the receiver sees gaps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seq      <= '0;
      overflow <= 1'b0;
    end else begin
      if (bus.pulse) begin
        seq <= seq + 1'b1;
      end
      if (drop) begin
        overflow <= 1'b1;
      end else if (bus.clr_ovf) begin
        overflow <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      shift_reg <= '0;
      bit_cnt   <= '0;
      div_cnt   <= '0;
      gap_cnt   <= '0;
      sck       <= 1'b0;
      sdo       <= 1'b0;
      sframe    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          shift_reg <= frame_word;
          sdo       <= frame_word[FL-1];
          sframe    <= 1'b1;
          sck       <= 1'b0;
          bit_cnt   <= '0;
          div_cnt   <= '0;
          state     <= ST_SHIFT;
        end
        ST_SHIFT: begin
          // Outputs are set one cycle ahead, so SCK rises when the next count reaches half a bit.
          if (div_cnt == DIV_BITS'(CLK_DIV - 1)) begin
            div_cnt <= '0;
            sck     <= 1'b0;
            if (bit_cnt == BIT_BITS'(FL - 1)) begin
              sframe  <= 1'b0;
              sdo     <= 1'b0;
              gap_cnt <= '0;
              state   <= ST_GAP;
            end else begin
              bit_cnt   <= bit_cnt + 1'b1;
              shift_reg <= shift_reg << 1;
              sdo       <= shift_reg[FL-2];
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
            sck     <= (div_cnt >= DIV_BITS'(CLK_DIV / 2 - 1));
          end
        end
        ST_GAP: begin
          if (gap_cnt == GAP_BITS'(GAP_CYCLES - 1)) begin
            state <= ST_IDLE;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
